dice_roll_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single dice-roll engine (LFSR → SIPO → post-process chain) between `N_REQ` requesters. It accepts one roll request at a time, validates the die code, and pulses the engine start. It then waits for the engine's done, and returns the roll tagged with the requester ID over a valid/ready response port. It sits between the Nios custom-instruction / UART front ends and the engine.

---
 rtl/dice_roll_arbiter.sv | 159 +++++++++++++++
 tb/tb_dice_roll_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_arbiter.sv
// Round-robin arbiter sharing one dice-roll engine between N_REQ requesters.
// Optional WAIT watchdog enabled by defining DICE_ARB_TIMEOUT_EN.
module dice_roll_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ID_W           = $clog2(N_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [4*N_REQ-1:0] req_die_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               eng_start_o,
    output logic [3:0]         eng_die_o,
    input  logic               eng_done_i,
    input  logic [4:0]         eng_result_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [ID_W-1:0]    rsp_id_o,
    output logic [4:0]         rsp_roll_o,
    output logic               rsp_error_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("dice_roll_arbiter: parameter out of range");
    end

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [3:0]      die_q, die_d;
    logic [4:0]      roll_q, roll_d;
    logic            err_q, err_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [3:0]      grant_die;
    logic            timeout;

    // First valid requester searching upward from last+1, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        int gidx;
        grant_found = 1'b0;
        gidx        = 0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = (int'(last_q) + k) % int'(N_REQ);
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                gidx        = idx;
            end
        end
        grant_id  = ID_W'(gidx);
        grant_die = req_die_i[4*gidx +: 4];
    end

`ifdef DICE_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == WAIT) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    // Fires in the WAIT cycle whose increment brings the count to TIMEOUT_CYCLES.
    assign timeout = (state_q == WAIT) && (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        die_d   = die_q;
        roll_d  = roll_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    id_d   = grant_id;
                    die_d  = grant_die;
                    last_d = grant_id;
                    if (grant_die <= 4'd5) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = RESP;
                        roll_d  = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (eng_done_i) begin
                    state_d = RESP;
                    roll_d  = eng_result_i;
                    err_d   = 1'b0;
                end else if (timeout) begin
                    state_d = RESP;
                    roll_d  = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            die_q   <= '0;
            roll_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            die_q   <= die_d;
            roll_q  <= roll_d;
            err_q   <= err_d;
        end
    end

    // Gated by reset so the grant output reads 0 while reset is held.
    assign req_ready_o = (state_q == IDLE && grant_found && !rst_i) ?
                         (N_REQ'(1) << grant_id) : '0;
    assign eng_start_o = (state_q == ISSUE);
    assign eng_die_o   = die_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_id_o    = id_q;
    assign rsp_roll_o  = roll_q;
    assign rsp_error_o = err_q;

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Directed self-checking bench for dice_roll_arbiter (N_REQ=4, TIMEOUT_CYCLES=8).
module tb_dice_roll_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_die;
    logic [3:0]  req_ready;
    logic        eng_start;
    logic [3:0]  eng_die;
    logic        eng_done;
    logic [4:0]  eng_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_roll;
    logic        rsp_error;

    int errs;
    int checks;

    dice_roll_arbiter #(
        .N_REQ          (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_die_i    (req_die),
        .req_ready_o  (req_ready),
        .eng_start_o  (eng_start),
        .eng_die_o    (eng_die),
        .eng_done_i   (eng_done),
        .eng_result_i (eng_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_roll_o   (rsp_roll),
        .rsp_error_o  (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_die    = 16'h0000;
        eng_done   = 1'b0;
        eng_result = 5'd0;
        rsp_ready  = 1'b1;
        step();
        step();
        checks++;
        if ({req_ready, eng_start, rsp_valid, rsp_error, rsp_id, rsp_roll, eng_die} !== 19'd0) begin
            errs++;
            $display("FAIL reset_outputs: got %0h want 0",
                     {req_ready, eng_start, rsp_valid, rsp_error, rsp_id, rsp_roll, eng_die});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        req_valid = 4'b0100;
        req_die   = 16'h0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errs++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        checks++;
        if ({eng_start, eng_die, req_ready} !== {1'b1, 4'd1, 4'b0000}) begin
            errs++;
            $display("FAIL single_issue: start=%b die=%0d ready=%b want 1 1 0000",
                     eng_start, eng_die, req_ready);
        end
        step();
        eng_done   = 1'b1;
        eng_result = 5'd4;
        #1;
        checks++;
        if ({eng_start, rsp_valid} !== 2'b00) begin
            errs++;
            $display("FAIL single_wait: start=%b valid=%b want 0 0", eng_start, rsp_valid);
        end
        step();
        eng_done = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_roll, rsp_error} !== {1'b1, 2'd2, 5'd4, 1'b0}) begin
            errs++;
            $display("FAIL single_resp: valid=%b id=%0d roll=%0d err=%b want 1 2 4 0",
                     rsp_valid, rsp_id, rsp_roll, rsp_error);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL single_idle: valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int seen[4]  = '{0, 0, 0, 0};
        do_reset();
        req_valid = 4'b1111;
        req_die   = {4'd3, 4'd2, 4'd1, 4'd0};
        rsp_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << order[r])) begin
                errs++;
                $display("FAIL rr_grant%0d: got %b want %b", r, req_ready, 4'(1 << order[r]));
            end
            step();
            checks++;
            if ({eng_start, eng_die} !== {1'b1, 4'(order[r])}) begin
                errs++;
                $display("FAIL rr_issue%0d: start=%b die=%0d want 1 %0d",
                         r, eng_start, eng_die, order[r]);
            end
            step();
            eng_done   = 1'b1;
            eng_result = 5'(order[r] + 10);
            step();
            eng_done = 1'b0;
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_roll, rsp_error} !==
                {1'b1, 2'(order[r]), 5'(order[r] + 10), 1'b0}) begin
                errs++;
                $display("FAIL rr_resp%0d: valid=%b id=%0d roll=%0d err=%b want 1 %0d %0d 0",
                         r, rsp_valid, rsp_id, rsp_roll, rsp_error, order[r], order[r] + 10);
            end
            if (rsp_valid === 1'b1) seen[rsp_id]++;
            step();
        end
        req_valid = 4'b0000;
        checks++;
        if (seen[0] != 2 || seen[1] != 1 || seen[2] != 1 || seen[3] != 1) begin
            errs++;
            $display("FAIL rr_counts: got %0d %0d %0d %0d want 2 1 1 1",
                     seen[0], seen[1], seen[2], seen[3]);
        end
    endtask

    task automatic test_invalid_die();
        req_valid = 4'b0010;
        req_die   = 16'h0090;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errs++;
            $display("FAIL inv_ready: got %b want 0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        checks++;
        if ({eng_start, rsp_valid, rsp_id, rsp_roll, rsp_error} !==
            {1'b0, 1'b1, 2'd1, 5'd0, 1'b1}) begin
            errs++;
            $display("FAIL inv_resp: start=%b valid=%b id=%0d roll=%0d err=%b want 0 1 1 0 1",
                     eng_start, rsp_valid, rsp_id, rsp_roll, rsp_error);
        end
        step();
        checks++;
        if ({rsp_valid, eng_start} !== 2'b00) begin
            errs++;
            $display("FAIL inv_idle: valid=%b start=%b want 0 0", rsp_valid, eng_start);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1000;
        req_die   = 16'h5000;
        step();
        req_valid = 4'b0000;
        step();
        eng_done   = 1'b1;
        eng_result = 5'd20;
        rsp_ready  = 1'b0;
        step();
        eng_done  = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_roll, rsp_error, req_ready} !==
                {1'b1, 2'd3, 5'd20, 1'b0, 4'b0000}) begin
                errs++;
                $display("FAIL bp_hold%0d: valid=%b id=%0d roll=%0d err=%b ready=%b",
                         i, rsp_valid, rsp_id, rsp_roll, rsp_error, req_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errs++;
            $display("FAIL bp_last: valid=%b want 1", rsp_valid);
        end
        step();
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b0001}) begin
            errs++;
            $display("FAIL bp_idle: valid=%b ready=%b want 0 0001", rsp_valid, req_ready);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_wait();
        int bad;
        req_valid = 4'b0010;
        req_die   = 16'h0020;
        step();
        req_valid = 4'b0000;
        step();
        req_valid = 4'b1111;
        rst       = 1'b1;
        #1;
        checks++;
        if ({req_ready, eng_start, rsp_valid, rsp_error, rsp_id, rsp_roll, eng_die} !== 19'd0) begin
            errs++;
            $display("FAIL rst_async: got %0h want 0",
                     {req_ready, eng_start, rsp_valid, rsp_error, rsp_id, rsp_roll, eng_die});
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errs++;
            $display("FAIL rst_next_grant: got %b want 0001", req_ready);
        end
        req_valid = 4'b0000;
        eng_done  = 1'b1;
        bad       = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid !== 1'b0 || eng_start !== 1'b0) bad++;
        end
        eng_done = 1'b0;
        checks++;
        if (bad !== 0) begin
            errs++;
            $display("FAIL rst_no_resp: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_done_during_issue();
        req_valid = 4'b0001;
        req_die   = 16'h0000;
        step();
        req_valid  = 4'b0000;
        eng_done   = 1'b1;
        eng_result = 5'd7;
        step();
        eng_done = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL early_done_w0: valid=%b want 0", rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL early_done_w1: valid=%b want 0", rsp_valid);
        end
        eng_done   = 1'b1;
        eng_result = 5'd9;
        step();
        eng_done = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_roll, rsp_error} !== {1'b1, 2'd0, 5'd9, 1'b0}) begin
            errs++;
            $display("FAIL early_done_resp: valid=%b id=%0d roll=%0d err=%b want 1 0 9 0",
                     rsp_valid, rsp_id, rsp_roll, rsp_error);
        end
        step();
    endtask

    task automatic test_timeout();
        req_valid = 4'b0100;
        req_die   = 16'h0400;
        step();
        req_valid = 4'b0000;
`ifdef DICE_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL tmo_early: valid=%b want 0 after 7 WAIT cycles", rsp_valid);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_roll, rsp_error} !== {1'b1, 2'd2, 5'd0, 1'b1}) begin
            errs++;
            $display("FAIL tmo_resp: valid=%b id=%0d roll=%0d err=%b want 1 2 0 1",
                     rsp_valid, rsp_id, rsp_roll, rsp_error);
        end
        step();
`else
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 1000; i++) begin
                step();
                if (rsp_valid !== 1'b0) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errs++;
                $display("FAIL no_tmo_wait: got %0d valid cycles want 0", bad);
            end
        end
`endif
        do_reset();
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_invalid_die();
        test_backpressure();
        test_reset_mid_wait();
        test_done_during_issue();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
